// File: rtl/record_unpacker.sv
// record_unpacker: buffers whole records and streams them out one word per cycle; RECORD_UNPACKER_LAST_EN enables word_last
module record_unpacker #(
  parameter int WordSize    = 8,
  parameter int RecordWords = 16,
  parameter int Depth       = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 rec_valid,
  input  logic [WordSize*RecordWords-1:0]      rec_data,
  output logic                                 rec_ready,
  output logic                                 word_valid,
  output logic [WordSize-1:0]                  word_data,
  input  logic                                 word_ready,
  output logic                                 word_last,
  output logic                                 full,
  output logic                                 empty,
  output logic [$clog2(Depth*RecordWords):0]   size
);
  localparam int StoragePosSize = $clog2(Depth * RecordWords);
  localparam int RecordPosSize  = $clog2(RecordWords);
  localparam int DepthPos       = $clog2(Depth);
  localparam logic [DepthPos:0] FullSlots = (DepthPos + 1)'(Depth);
  logic [RecordWords-1:0][WordSize-1:0] storage_q [Depth];
  logic [DepthPos:0]       wr_rec_q, wr_rec_d, used_slots;
  logic [StoragePosSize:0] rd_word_q, rd_word_d;
  logic                    push, pop;
  always_comb begin
    used_slots = wr_rec_q - rd_word_q[StoragePosSize:RecordPosSize];
    full       = used_slots == FullSlots;
    rec_ready  = !full;
    size       = {wr_rec_q, {RecordPosSize{1'b0}}} - rd_word_q;
    empty      = size == '0;
    word_valid = !empty;
    word_data  = storage_q[rd_word_q[StoragePosSize-1:RecordPosSize]][rd_word_q[RecordPosSize-1:0]];
    push       = rec_valid && rec_ready;
    pop        = word_valid && word_ready;
    wr_rec_d   = wr_rec_q + (DepthPos + 1)'(push);
    rd_word_d  = rd_word_q + (StoragePosSize + 1)'(pop);
  end
`ifdef RECORD_UNPACKER_LAST_EN
  assign word_last = word_valid && (rd_word_q[RecordPosSize-1:0] == RecordPosSize'(RecordWords - 1));
`else
  assign word_last = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_rec_q  <= '0;
      rd_word_q <= '0;
    end else begin
      wr_rec_q  <= wr_rec_d;
      rd_word_q <= rd_word_d;
    end
  end
  always_ff @(posedge clk)
    if (!reset && push) storage_q[wr_rec_q[DepthPos-1:0]] <= rec_data;
endmodule

// File: tb/tb_record_unpacker.sv
// tb_record_unpacker: directed tests of record_unpacker with WordSize=8, RecordWords=4, Depth=2
module tb_record_unpacker;
`ifdef RECORD_UNPACKER_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rec_valid = 1'b0;
  logic [31:0] rec_data = '0;
  logic        rec_ready, word_valid, word_ready, word_last, full, empty;
  logic [7:0]  word_data;
  logic [3:0]  size;
  int          n_checks = 0;
  int          n_fail = 0;

  record_unpacker #(.WordSize(8), .RecordWords(4), .Depth(2)) dut (
    .clk(clk), .reset(reset), .rec_valid(rec_valid), .rec_data(rec_data),
    .rec_ready(rec_ready), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .word_last(word_last), .full(full),
    .empty(empty), .size(size)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    word_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (rec_ready !== 1'b1 || full !== 1'b0 || empty !== 1'b1 || size !== 4'd0 ||
        word_valid !== 1'b0 || word_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rec_ready=%b full=%b empty=%b size=%0d word_valid=%b word_last=%b want 1 0 1 0 0 0",
               rec_ready, full, empty, size, word_valid, word_last);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_w [4];
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    word_ready = 1'b1;
    rec_valid = 1'b1;
    rec_data = 32'h44332211;
    step();
    rec_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (word_valid !== 1'b1 || word_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL single_word%0d: valid=%b data=%h want 1 %h", i, word_valid, word_data, exp_w[i]);
      end
      n_checks++;
      if (word_last !== (LastEn && i == 3)) begin
        n_fail++;
        $display("FAIL single_last%0d: word_last=%b want %b", i, word_last, LastEn && i == 3);
      end
      step();
    end
    n_checks++;
    if (empty !== 1'b1 || size !== 4'd0 || word_valid !== 1'b0 || word_last !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drained: empty=%b size=%0d valid=%b last=%b want 1 0 0 0", empty, size, word_valid, word_last);
    end
  endtask

  task automatic test_full();
    logic [7:0] exp_w [8];
    exp_w = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc};
    word_ready = 1'b0;
    rec_valid = 1'b1;
    rec_data = 32'h88776655;
    step();
    rec_data = 32'hccbbaa99;
    step();
    n_checks++;
    if (full !== 1'b1 || rec_ready !== 1'b0 || size !== 4'd8) begin
      n_fail++;
      $display("FAIL full_two_recs: full=%b rec_ready=%b size=%0d want 1 0 8", full, rec_ready, size);
    end
    rec_data = 32'hdeadbeef;
    step();
    rec_valid = 1'b0;
    n_checks++;
    if (full !== 1'b1 || size !== 4'd8) begin
      n_fail++;
      $display("FAIL full_third_ignored: full=%b size=%0d want 1 8", full, size);
    end
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (word_valid !== 1'b1 || word_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL full_drain%0d: valid=%b data=%h want 1 %h", i, word_valid, word_data, exp_w[i]);
      end
      step();
    end
    n_checks++;
    if (empty !== 1'b1 || size !== 4'd0) begin
      n_fail++;
      $display("FAIL full_drained: empty=%b size=%0d want 1 0", empty, size);
    end
  endtask

  task automatic test_free_slot();
    word_ready = 1'b0;
    rec_valid = 1'b1;
    rec_data = 32'h88776655;
    step();
    rec_data = 32'hccbbaa99;
    step();
    rec_valid = 1'b0;
    word_ready = 1'b1;
    step();
    step();
    step();
    n_checks++;
    if (full !== 1'b1 || rec_ready !== 1'b0 || size !== 4'd5 || word_data !== 8'h88) begin
      n_fail++;
      $display("FAIL free_after3: full=%b rec_ready=%b size=%0d data=%h want 1 0 5 88", full, rec_ready, size, word_data);
    end
    step();
    word_ready = 1'b0;
    n_checks++;
    if (rec_ready !== 1'b1 || full !== 1'b0 || size !== 4'd4 || word_data !== 8'h99) begin
      n_fail++;
      $display("FAIL free_after4: rec_ready=%b full=%b size=%0d data=%h want 1 0 4 99", rec_ready, full, size, word_data);
    end
    rec_valid = 1'b1;
    rec_data = 32'h04030201;
    word_ready = 1'b1;
    step();
    rec_valid = 1'b0;
    word_ready = 1'b0;
    n_checks++;
    if (size !== 4'd7 || full !== 1'b1 || word_data !== 8'haa) begin
      n_fail++;
      $display("FAIL free_push_take: size=%0d full=%b data=%h want 7 1 aa", size, full, word_data);
    end
    word_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (word_data !== 8'h01 || size !== 4'd4) begin
      n_fail++;
      $display("FAIL free_next_rec: data=%h size=%0d want 01 4", word_data, size);
    end
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL free_drained: empty=%b want 1", empty);
    end
  endtask

  task automatic test_back_to_back();
    int pushed = 0;
    int got = 0;
    int cycles = 0;
    bit gap = 0;
    bit over = 0;
    word_ready = 1'b1;
    while (got < 80 && cycles < 300) begin
      if (word_valid) begin
        n_checks++;
        if (word_data !== 8'(got) || word_last !== (LastEn && (got % 4) == 3)) begin
          n_fail++;
          $display("FAIL b2b_word%0d: data=%h last=%b want %h %b", got, word_data, word_last, 8'(got), LastEn && (got % 4) == 3);
        end
        got++;
      end else if (got > 0) gap = 1;
      if (size > 4'd8) over = 1;
      rec_valid = pushed < 20;
      rec_data = {8'(pushed * 4 + 3), 8'(pushed * 4 + 2), 8'(pushed * 4 + 1), 8'(pushed * 4)};
      if (rec_valid && rec_ready) pushed++;
      step();
      cycles++;
    end
    rec_valid = 1'b0;
    n_checks++;
    if (got != 80) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d words want 80", got);
    end
    n_checks++;
    if (gap || over) begin
      n_fail++;
      $display("FAIL b2b_flow: gap=%b size_over=%b want 0 0", gap, over);
    end
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drained: empty=%b want 1", empty);
    end
  endtask

  task automatic test_reset_mid();
    word_ready = 1'b0;
    rec_valid = 1'b1;
    rec_data = 32'h88776655;
    step();
    rec_valid = 1'b0;
    word_ready = 1'b1;
    step();
    step();
    word_ready = 1'b0;
    n_checks++;
    if (word_data !== 8'h77 || size !== 4'd2) begin
      n_fail++;
      $display("FAIL mid_partial: data=%h size=%0d want 77 2", word_data, size);
    end
    reset = 1'b1;
    rec_valid = 1'b1;
    word_ready = 1'b1;
    rec_data = 32'hdeadbeef;
    step();
    reset = 1'b0;
    rec_valid = 1'b0;
    word_ready = 1'b0;
    n_checks++;
    if (empty !== 1'b1 || size !== 4'd0 || rec_ready !== 1'b1 || word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: empty=%b size=%0d rec_ready=%b valid=%b want 1 0 1 0", empty, size, rec_ready, word_valid);
    end
    rec_valid = 1'b1;
    rec_data = 32'hccbbaa99;
    step();
    rec_valid = 1'b0;
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 8'h99 || size !== 4'd4) begin
      n_fail++;
      $display("FAIL mid_new_rec: valid=%b data=%h size=%0d want 1 99 4", word_valid, word_data, size);
    end
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_drained: empty=%b want 1", empty);
    end
  endtask

  initial begin
    word_ready = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_free_slot();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
